// File: rtl/fb_video_out.sv
// Raster scan-out engine: walks a 3-bit framebuffer one pixel ahead of the
// display and emits hsync/vsync/rgb aligned to the returned pixel data.
module fb_video_out #(
  parameter int H_VIS   = 256,
  parameter int H_FP    = 7,
  parameter int H_SYNC  = 23,
  parameter int H_BP    = 23,
  parameter int V_VIS   = 240,
  parameter int V_FP    = 14,
  parameter int V_SYNC  = 3,
  parameter int V_BP    = 5,
  parameter int PIX_DIV = 2,
  parameter int ADDR_W  = $clog2(H_VIS*V_VIS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd,
  input  logic [2:0]        fb_data,
  output logic              hsync,
  output logic              vsync,
  output logic [2:0]        rgb,
  output logic              frame_start,
  output logic [15:0]       frame_cnt
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_W   = $clog2(H_TOT);
  localparam int V_W   = $clog2(V_TOT);
  localparam int DIV_W = $clog2(PIX_DIV);

  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOT - 1);
  localparam logic [H_W-1:0]   H_VIS_C  = H_W'(H_VIS);
  localparam logic [H_W-1:0]   HS_FIRST = H_W'(H_VIS + H_FP);
  localparam logic [H_W-1:0]   HS_LAST  = H_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOT - 1);
  localparam logic [V_W-1:0]   V_VIS_C  = V_W'(V_VIS);
  localparam logic [V_W-1:0]   VS_FIRST = V_W'(V_VIS + V_FP);
  localparam logic [V_W-1:0]   VS_LAST  = V_W'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0]  r_divCnt;
  logic [H_W-1:0]    r_h;
  logic [V_W-1:0]    r_v;
  logic [ADDR_W-1:0] r_addr;
  logic [H_W-1:0]    r_hD;
  logic [V_W-1:0]    r_vD;
  logic              r_visD;
  logic              r_fbRd;
  logic [ADDR_W-1:0] r_fbAddr;
  logic              r_hsync;
  logic              r_vsync;
  logic [2:0]        r_rgb;
  logic              r_frameStart;
  logic [15:0]       r_frameCnt;

  logic w_tick;
  logic w_stage1;
  logic w_vis;
  logic w_hWrap;
  logic w_vWrap;

  // Stage 1 is the enabled clk right after a tick; it stalls with en so fb_data is still consumed.
  assign w_tick   = en && (r_divCnt == '0);
  assign w_stage1 = en && (r_divCnt == DIV_W'(1));
  assign w_vis    = (r_h < H_VIS_C) && (r_v < V_VIS_C);
  assign w_hWrap  = (r_h == H_LAST);
  assign w_vWrap  = (r_v == V_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_divCnt <= '0;
      r_h      <= '0;
      r_v      <= '0;
      r_addr   <= '0;
    end else if (en) begin
      r_divCnt <= (r_divCnt == DIV_LAST) ? '0 : r_divCnt + DIV_W'(1);
      if (w_tick) begin
        if (w_hWrap) begin
          r_h <= '0;
          r_v <= w_vWrap ? '0 : r_v + V_W'(1);
        end else begin
          r_h <= r_h + H_W'(1);
        end
        if (w_hWrap && w_vWrap) begin
          r_addr <= '0;
        end else if (w_vis) begin
          r_addr <= r_addr + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fbRd   <= 1'b0;
      r_fbAddr <= '0;
      r_hD     <= '0;
      r_vD     <= '0;
      r_visD   <= 1'b0;
    end else begin
      r_fbRd <= w_tick && w_vis;
      if (w_tick) begin
        r_hD   <= r_h;
        r_vD   <= r_v;
        r_visD <= w_vis;
        if (w_vis) begin
          r_fbAddr <= r_addr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rgb        <= 3'b000;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_frameStart <= 1'b0;
      r_frameCnt   <= 16'd0;
    end else begin
      r_frameStart <= 1'b0;
      if (w_stage1) begin
        r_rgb   <= r_visD ? fb_data : 3'b000;
        r_hsync <= !((r_hD >= HS_FIRST) && (r_hD <= HS_LAST));
        r_vsync <= !((r_vD >= VS_FIRST) && (r_vD <= VS_LAST));
        if ((r_hD == '0) && (r_vD == '0)) begin
          r_frameStart <= 1'b1;
          r_frameCnt   <= r_frameCnt + 16'd1;
        end
      end
    end
  end

  assign fb_rd       = r_fbRd;
  assign fb_addr     = r_fbAddr;
  assign rgb         = r_rgb;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frameStart;
  assign frame_cnt   = r_frameCnt;

endmodule

// File: tb/tb_fb_video_out.sv
// Bench for fb_video_out: small raster, random framebuffer contents, random
// enable/reset, checked every clk against an arithmetic pixel-index model.
module tb_fb_video_out;

  localparam int H_VIS   = 8;
  localparam int H_FP    = 2;
  localparam int H_SYNC  = 3;
  localparam int H_BP    = 2;
  localparam int V_VIS   = 4;
  localparam int V_FP    = 1;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 1;
  localparam int PIX_DIV = 2;
  localparam int ADDR_W  = $clog2(H_VIS*V_VIS);
  localparam int H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FB_SIZE = H_VIS * V_VIS;

  logic              clock;
  logic              reset;
  logic              en;
  logic [ADDR_W-1:0] fbAddr;
  logic              fbRd;
  logic [2:0]        fbData;
  logic              hsync;
  logic              vsync;
  logic [2:0]        rgb;
  logic              frameStart;
  logic [15:0]       frameCnt;

  logic [2:0] mem [FB_SIZE];

  int compared = 0;
  int mismatched = 0;

  // Expected register state after the most recent clock edge.
  int          enEdges;
  logic        mFbRd;
  int          mFbAddr;
  logic        mHsync;
  logic        mVsync;
  logic [2:0]  mRgb;
  logic        mFrameStart;
  logic [15:0] mFrameCnt;

  int   fsCount;
  int   vsFalls;
  logic prevVs;

  fb_video_out #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PIX_DIV(PIX_DIV), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clock),
    .reset(reset),
    .en(en),
    .fb_addr(fbAddr),
    .fb_rd(fbRd),
    .fb_data(fbData),
    .hsync(hsync),
    .vsync(vsync),
    .rgb(rgb),
    .frame_start(frameStart),
    .frame_cnt(frameCnt)
  );

  // Framebuffer read port: data presented while the address is held after the strobe.
  assign fbData = mem[fbAddr];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Pixel n of the scan is raster position (n mod H_TOT, (n div H_TOT) mod V_TOT).
  task automatic modelEdge(input logic rstIn, input logic enIn);
    int n, h, v;
    bit vis;
    if (!rstIn) begin
      enEdges = 0; mFbRd = 1'b0; mFbAddr = 0; mHsync = 1'b1; mVsync = 1'b1;
      mRgb = 3'b000; mFrameStart = 1'b0; mFrameCnt = 16'd0;
    end else if (!enIn) begin
      mFbRd = 1'b0;
      mFrameStart = 1'b0;
    end else begin
      n = enEdges / PIX_DIV;
      h = n % H_TOT;
      v = (n / H_TOT) % V_TOT;
      vis = (h < H_VIS) && (v < V_VIS);
      mFrameStart = 1'b0;
      if (enEdges % PIX_DIV == 0) begin
        mFbRd = vis;
        if (vis) mFbAddr = v * H_VIS + h;
      end else begin
        mFbRd = 1'b0;
        if (enEdges % PIX_DIV == 1) begin
          mRgb   = vis ? mem[v * H_VIS + h] : 3'b000;
          mHsync = !((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC));
          mVsync = !((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC));
          if (h == 0 && v == 0) begin
            mFrameStart = 1'b1;
            mFrameCnt = mFrameCnt + 16'd1;
          end
        end
      end
      enEdges++;
    end
  endtask

  task automatic applyStimulus(input logic rstIn, input logic enIn);
    reset = rstIn;
    en = enIn;
    modelEdge(rstIn, enIn);
    @(negedge clock);
    checkOutput("fb_rd", 32'(fbRd), 32'(mFbRd));
    checkOutput("fb_addr", 32'(fbAddr), 32'(mFbAddr));
    checkOutput("hsync", 32'(hsync), 32'(mHsync));
    checkOutput("vsync", 32'(vsync), 32'(mVsync));
    checkOutput("rgb", 32'(rgb), 32'(mRgb));
    checkOutput("frame_start", 32'(frameStart), 32'(mFrameStart));
    checkOutput("frame_cnt", 32'(frameCnt), 32'(mFrameCnt));
    if (frameStart) fsCount++;
    if (prevVs && !vsync) vsFalls++;
    prevVs = vsync;
  endtask

  initial begin
    reset = 1'b0;
    en = 1'b0;
    fsCount = 0;
    vsFalls = 0;
    prevVs = 1'b1;
    for (int i = 0; i < FB_SIZE; i++) mem[i] = 3'b101;
    @(negedge clock);

    // Reset hold, then release with a constant colour in the framebuffer.
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("first_rd_addr", 32'(fbAddr), 32'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("first_rgb", 32'(rgb), 32'd5);
    checkOutput("first_frame_cnt", 32'(frameCnt), 32'd1);
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b1);

    // Random image, enable held low for 10 clks mid-line.
    for (int i = 0; i < FB_SIZE; i++) mem[i] = 3'($urandom_range(0, 7));
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 400; i++) applyStimulus(1'b1, 1'b1);

    // Random enable gaps, occasional mid-frame resets and image rewrites.
    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(0, 999) == 0)
        for (int j = 0; j < FB_SIZE; j++) mem[j] = 3'($urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 599) != 0), ($urandom_range(0, 7) != 0));
    end

    // Long uninterrupted run: 201 frames started after reset.
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    fsCount = 0;
    vsFalls = 0;
    prevVs = vsync;
    for (int i = 0; i < 48200; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("frames_cnt_201", 32'(frameCnt), 32'd201);
    checkOutput("frame_start_pulses", 32'(fsCount), 32'd201);
    checkOutput("vsync_falls", 32'(vsFalls), 32'd201);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
